// File: rtl/lcd_bus_pkg.sv
// Shared types and constants for the display bus scheduler.
// Holds the FSM encoding, bus timing constants and init command ROM.
package lcd_bus_pkg;

  typedef enum logic [1:0] {
    RST_HOLD,
    INIT_LOAD,
    SHIFT,
    IDLE
  } state_t;

  localparam int LCD_BIT_CYCLES  = 2;
  localparam int LCD_BYTE_CYCLES = 16;

  localparam int INIT_ROM_LEN = 6;

  localparam logic [7:0] INIT_ROM [INIT_ROM_LEN] = '{
    8'h21, 8'hC8, 8'h06, 8'h13, 8'h20, 8'h0C
  };

endpackage

// File: rtl/lcd_byte_shifter.sv
// MSB-first byte serializer for the display bus.
// Two clocks per bit: SCLK low with data set up, then SCLK high.
module lcd_byte_shifter
  import lcd_bus_pkg::*;
(
  input  logic       clk_12_8M__12_8K,
  input  logic       Reset,
  input  logic       load,
  input  logic [7:0] byte_in,
  output logic       SCLK,
  output logic       SDIN,
  output logic       last
);

  logic [7:0] sr;
  logic [2:0] bitcnt;
  logic       phase;
  logic       active;

  // Shift register, bit counter and phase; the byte drains to zero so
  // SDIN rests low between bytes.
  always_ff @(posedge clk_12_8M__12_8K or negedge Reset) begin
    if (!Reset) begin
      sr     <= '0;
      bitcnt <= '0;
      phase  <= 1'b0;
      active <= 1'b0;
    end else if (load) begin
      sr     <= byte_in;
      bitcnt <= 3'd7;
      phase  <= 1'b0;
      active <= 1'b1;
    end else if (active) begin
      if (!phase) begin
        phase <= 1'b1;
      end else begin
        phase <= 1'b0;
        sr    <= {sr[6:0], 1'b0};
        if (bitcnt == 3'd0) active <= 1'b0;
        else                bitcnt <= bitcnt - 3'd1;
      end
    end
  end

  // Phase is only ever high while a byte is in flight.
  always_comb begin
    SCLK = phase;
    SDIN = sr[7];
    last = phase & (bitcnt == 3'd0);
  end

endmodule

// File: rtl/lcd_bus_sched.sv
// Display bus sequencer: reset pulse, init command stream, then
// round-robin sharing of the byte-serial bus between two requesters.
module lcd_bus_sched
  import lcd_bus_pkg::*;
#(
  parameter int RES_CYCLES = 8,
  parameter int INIT_LEN   = 6
) (
  input  logic       clk_12_8M__12_8K,
  input  logic       Reset,
  input  logic [1:0] req,
  input  logic [7:0] data0,
  input  logic [7:0] data1,
  input  logic       dc0,
  input  logic       dc1,
  output logic [1:0] gnt,
  output logic       done,
  output logic       ready,
  output logic       SCLK,
  output logic       SDIN,
  output logic       DnC,
  output logic       nSCE,
  output logic       nRES
);

  localparam int CW = (RES_CYCLES > 1) ? $clog2(RES_CYCLES) : 1;
  localparam int IW = $clog2(INIT_LEN + 1);

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_d;
  logic [IW-1:0] idx, idx_d;
  logic          ptr, ptr_d;
  logic [1:0]    gnt_d;
  logic          done_d, ready_d, dnc_d, nsce_d, nres_d;
  logic          win;
  logic          load;
  logic [7:0]    load_byte;
  logic          last;
  logic          cnt_end;
  logic          idx_end;

  assign cnt_end = (cnt == CW'(RES_CYCLES - 1));
  assign idx_end = (idx == IW'(INIT_LEN - 1));

  // Round-robin winner: a lone request wins, a tie goes away from ptr.
  always_comb begin
    win = req[1];
    if (req[0] && req[1]) win = ~ptr;
  end

  // State register.
  always_ff @(posedge clk_12_8M__12_8K or negedge Reset) begin
    if (!Reset) state <= RST_HOLD;
    else        state <= state_nx;
  end

  // Next-state logic; ready separates init bytes from requester bytes.
  always_comb begin
    state_nx = state;
    unique case (state)
      RST_HOLD:  if (cnt_end) state_nx = INIT_LOAD;
      INIT_LOAD: state_nx = SHIFT;
      SHIFT: begin
        if (last) begin
          if (!ready && !idx_end) state_nx = INIT_LOAD;
          else                    state_nx = IDLE;
        end
      end
      IDLE:      if (|req) state_nx = SHIFT;
      default:   state_nx = RST_HOLD;
    endcase
  end

  // Output and datapath next values for the registered bus/handshake.
  always_comb begin
    cnt_d     = cnt;
    idx_d     = idx;
    ptr_d     = ptr;
    gnt_d     = gnt;
    done_d    = 1'b0;
    ready_d   = ready;
    dnc_d     = DnC;
    nsce_d    = nSCE;
    nres_d    = nRES;
    load      = 1'b0;
    load_byte = win ? data1 : data0;
    unique case (state)
      RST_HOLD: begin
        cnt_d = cnt + 1'b1;
        if (cnt_end) nres_d = 1'b1;
      end
      INIT_LOAD: begin
        load      = 1'b1;
        load_byte = INIT_ROM[idx];
        dnc_d     = 1'b0;
        nsce_d    = 1'b0;
      end
      SHIFT: begin
        if (last) begin
          nsce_d = 1'b1;
          if (!ready) begin
            idx_d = idx + 1'b1;
            if (idx_end) ready_d = 1'b1;
          end else begin
            gnt_d  = 2'b00;
            done_d = 1'b1;
          end
        end
      end
      IDLE: begin
        if (|req) begin
          load   = 1'b1;
          ptr_d  = win;
          dnc_d  = win ? dc1 : dc0;
          gnt_d  = win ? 2'b10 : 2'b01;
          nsce_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Registered outputs and bookkeeping.
  always_ff @(posedge clk_12_8M__12_8K or negedge Reset) begin
    if (!Reset) begin
      cnt   <= '0;
      idx   <= '0;
      ptr   <= 1'b1;
      gnt   <= 2'b00;
      done  <= 1'b0;
      ready <= 1'b0;
      DnC   <= 1'b0;
      nSCE  <= 1'b1;
      nRES  <= 1'b0;
    end else begin
      cnt   <= cnt_d;
      idx   <= idx_d;
      ptr   <= ptr_d;
      gnt   <= gnt_d;
      done  <= done_d;
      ready <= ready_d;
      DnC   <= dnc_d;
      nSCE  <= nsce_d;
      nRES  <= nres_d;
    end
  end

  lcd_byte_shifter u_shifter (
    .clk_12_8M__12_8K (clk_12_8M__12_8K),
    .Reset            (Reset),
    .load             (load),
    .byte_in          (load_byte),
    .SCLK             (SCLK),
    .SDIN             (SDIN),
    .last             (last)
  );

endmodule

// File: doc/lcd_bus_sched.md
# lcd_bus_sched

Sequencer and arbiter for the PCD8544-style serial display bus: SCLK, SDIN, DnC, nSCE and nRES.
- After reset it drives the display reset pulse and streams a fixed init command sequence.
- It then shares the byte-serial bus between two requesters, round-robin, one byte per grant.
- It sits between the display-content logic and the display pins, in the clk_12_8M__12_8K domain.

## Interface
Parameters:
- RES_CYCLES, 8: clock cycles nRES is held low after reset release.
- INIT_LEN, 6: number of init command bytes taken from the package ROM.

Ports:
- clk_12_8M__12_8K  in  1  block clock; all state changes on its rising edge.
- Reset  in  1  reset, asynchronous, active-low.
- req  in  2  per-requester byte request; held high until that requester's done.
- data0, data1  in  8  byte for requester 0 / 1; sampled only at grant.
- dc0, dc1  in  1  DnC value for that byte (0 = command, 1 = data); sampled at grant.
- gnt  out  2  one-hot; high for the whole transfer of the granted byte.
- done  out  1  1-cycle pulse when a granted byte completes.
- ready  out  1  high once the init sequence has finished.
- SCLK, SDIN, DnC, nSCE, nRES  out  1 each  display bus.

## Operation
Reset values while Reset = 0:
- SCLK = 0, SDIN = 0, DnC = 0, nSCE = 1, nRES = 0.
- gnt = 0, done = 0, ready = 0.
- State = RST_HOLD, round-robin pointer = 1 (requester 0 wins the first tie).

States:
- RST_HOLD: nRES = 0 while a counter runs 0..RES_CYCLES-1. At the edge where the counter equals RES_CYCLES-1, nRES <= 1 and state -> INIT_LOAD.
- INIT_LOAD: load ROM[idx] into the shifter, DnC <= 0, nSCE <= 0 -> SHIFT (init). gnt and done stay 0 for init bytes.
- SHIFT: per bit, MSB first, 2 cycles per bit:
  - phase 0: SCLK = 0, SDIN = current bit.
  - phase 1: SCLK = 1, SDIN unchanged.
  - After bit 0, phase 1: nSCE <= 1 and SCLK <= 0.
  - Init byte: idx+1; if idx+1 = INIT_LEN go to IDLE and set ready <= 1, else go to INIT_LOAD.
  - Requester byte: gnt <= 0, done <= 1 for one cycle, go to IDLE.
- IDLE: when req ≠ 0, pick the winner:
  - Only one request bit set: that requester wins.
  - Both set: the requester not equal to the pointer wins.
  - On the same edge: pointer <= winner, latch that requester's data and dc into shifter and DnC, gnt <= one-hot winner, nSCE <= 0, go to SHIFT.
- ready stays 1 until the next reset.
- Dropping req during a transfer does not abort it; the byte completes and done still pulses.
- req set during RST_HOLD or INIT is held off and served from IDLE.

## Timing
- Each byte occupies 16 cycles with nSCE = 0.
- Grant edge to done: done is high in cycle 17 after the grant edge; nSCE = 1 in that same cycle.
- Back-to-back transfers: a request seen in IDLE is granted at the next edge. Minimum nSCE-high gap between two bytes is 1 cycle (the IDLE/done cycle).
- Init timing from reset release:
  - RES_CYCLES cycles with nRES low.
  - 1 INIT_LOAD cycle per byte.
  - 16 SHIFT cycles per byte.
  - ready = 1 after RES_CYCLES + INIT_LEN*17 cycles.
- SDIN changes only while SCLK = 0, so the display samples it on SCLK rising.
- Async reset mid-byte:
  - All outputs return to reset values immediately.
  - nRES drops to 0, the partial byte is abandoned and no done is issued.
  - The full init sequence reruns.
- Requests present in the same cycle as done: arbitrated in the following IDLE cycle using the updated pointer.

## Structure
- Package lcd_bus_pkg holds:
  - the state enum (RST_HOLD, INIT_LOAD, SHIFT, IDLE);
  - LCD_BIT_CYCLES = 2 and LCD_BYTE_CYCLES = 16;
  - the init ROM localparam array: 8'h21, 8'hC8, 8'h06, 8'h13, 8'h20, 8'h0C.
- Sub-module lcd_byte_shifter holds the 8-bit shift register, bit counter and phase bit.
  - Inputs: load, byte.
  - Outputs: SCLK, SDIN, last (high during bit 0, phase 1).
- The scheduler FSM, round-robin pointer and init index stay in lcd_bus_sched.

## Test plan
- Reset release, RES_CYCLES = 8: nRES low for exactly 8 cycles, then 6 bytes 21 C8 06 13 20 0C on SDIN, MSB first with DnC = 0; ready rises at cycle 110; gnt and done stay 0 throughout.
- After ready, req = 01, data0 = 8'hA5, dc0 = 1: gnt = 01 for 16 cycles; SDIN samples at SCLK rising read 1,0,1,0,0,1,0,1; DnC = 1; done pulses in cycle 17.
- req = 11 held with data0 = 8'h11, data1 = 8'h22: grants alternate 01, 10, 01, …; a 1-cycle nSCE-high gap separates every pair of bytes.
- req0 dropped at cycle 5 of its transfer: all 8 bits still shift and done still pulses once.
- Reset asserted at cycle 9 of a requester byte: nSCE = 1, nRES = 0, gnt = 0 immediately; no done; after release the init sequence replays and ready is 0 until it finishes.
- req = 10 asserted during init: no gnt before ready; gnt = 10 on the first edge after ready rises.
